// File: rtl/fp_divsqrt_rr_pkg.sv
// Shared types for the round-robin div/sqrt lane dispatcher: lane states,
// the fpnew-encoded operation/rounding/status types, and pointer wrap helper.
package fp_divsqrt_rr_pkg;

  // Subset of the fpnew encodings used on the lane interface.
  typedef enum logic [3:0] {
    OP_DIV  = 4'd4,
    OP_SQRT = 4'd5
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    ROD = 3'd5,
    DYN = 3'd7
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } lane_state_e;

  // Increment modulo n; n need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fp_divsqrt_rr_slot.sv
// One lane's occupancy FSM plus its result/status/tag buffer.
module fp_divsqrt_rr_slot
  import fp_divsqrt_rr_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter type         TagType = logic [3:0]
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_issue,
  input  TagType           i_tag,
  input  logic             i_lane_valid,
  input  logic [WIDTH-1:0] i_lane_result,
  input  status_t          i_lane_status,
  input  logic             i_retire,
  output lane_state_e      o_state,
  output logic             o_lane_ready,
  output logic [WIDTH-1:0] o_result,
  output status_t          o_status,
  output TagType           o_tag
);

  lane_state_e      r_state;
  logic [WIDTH-1:0] r_result;
  status_t          r_status;
  TagType           r_tag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_status <= '0;
      r_tag    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_issue) begin
            r_state <= BUSY;
            r_tag   <= i_tag;
          end
        end
        BUSY: begin
          // A lane finishing in the flush cycle has already handed its result over.
          if (i_flush) begin
            r_state <= i_lane_valid ? IDLE : DRAIN;
          end else if (i_lane_valid) begin
            r_state  <= DONE;
            r_result <= i_lane_result;
            r_status <= i_lane_status;
          end
        end
        DONE: begin
          if (i_flush || i_retire) r_state <= IDLE;
        end
        DRAIN: begin
          if (i_lane_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_lane_ready = (r_state == BUSY) || (r_state == DRAIN);
  assign o_result     = r_result;
  assign o_status     = r_status;
  assign o_tag        = r_tag;

endmodule

// File: rtl/pipe_fp_divsqrt_rr.sv
// Round-robin dispatcher/collector over NUM_LANES iterative FP div/sqrt lanes;
// results return in issue order with output backpressure and a draining flush.
module pipe_fp_divsqrt_rr
  import fp_divsqrt_rr_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_LANES = 5,
  parameter type         TagType   = logic [3:0]
) (
  input  logic                            CLK_i,
  input  logic                            RST_i,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [1:0][WIDTH-1:0]           operands_i,
  input  operation_e                      op_i,
  input  roundmode_e                      rnd_mode_i,
  input  TagType                          tag_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WIDTH-1:0]                result_o,
  output status_t                         status_o,
  output TagType                          tag_o,
  output logic                            busy_o,
  output logic [NUM_LANES-1:0]            lane_in_valid_o,
  input  logic [NUM_LANES-1:0]            lane_in_ready_i,
  output logic [1:0][WIDTH-1:0]           lane_operands_o,
  output operation_e                      lane_op_o,
  output roundmode_e                      lane_rnd_mode_o,
  input  logic [NUM_LANES-1:0]            lane_out_valid_i,
  output logic [NUM_LANES-1:0]            lane_out_ready_o,
  input  logic [NUM_LANES-1:0][WIDTH-1:0] lane_result_i,
  input  status_t [NUM_LANES-1:0]         lane_status_i
);

  localparam int unsigned PtrW = $clog2(NUM_LANES);

  logic [PtrW-1:0]      r_dp;
  logic [PtrW-1:0]      r_rp;
  lane_state_e          w_state  [NUM_LANES];
  logic [WIDTH-1:0]     w_result [NUM_LANES];
  status_t              w_status [NUM_LANES];
  TagType               w_tag    [NUM_LANES];
  logic [NUM_LANES-1:0] w_busy;
  logic [NUM_LANES-1:0] w_issue;
  logic [NUM_LANES-1:0] w_retire;
  logic                 w_accept;
  logic                 w_retire_hs;

  // Issue readiness only looks at registered lane state, never at out_ready_i.
  assign in_ready_o  = (w_state[r_dp] == IDLE) & lane_in_ready_i[r_dp] & ~flush_i;
  assign w_accept    = in_valid_i & in_ready_o;
  assign out_valid_o = (w_state[r_rp] == DONE);
  assign w_retire_hs = out_valid_o & out_ready_i & ~flush_i;

  assign result_o = w_result[r_rp];
  assign status_o = w_status[r_rp];
  assign tag_o    = w_tag[r_rp];
  assign busy_o   = |w_busy;

  assign lane_operands_o = operands_i;
  assign lane_op_o       = op_i;
  assign lane_rnd_mode_o = rnd_mode_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_in_valid_o[g] = in_valid_i & (r_dp == PtrW'(g)) & (w_state[g] == IDLE) & ~flush_i;
    assign w_issue[g]         = lane_in_valid_o[g] & lane_in_ready_i[g];
    assign w_retire[g]        = w_retire_hs & (r_rp == PtrW'(g));
    assign w_busy[g]          = (w_state[g] != IDLE);

    fp_divsqrt_rr_slot #(
      .WIDTH   (WIDTH),
      .TagType (TagType)
    ) u_slot (
      .i_clk         (CLK_i),
      .i_rst         (RST_i),
      .i_flush       (flush_i),
      .i_issue       (w_issue[g]),
      .i_tag         (tag_i),
      .i_lane_valid  (lane_out_valid_i[g]),
      .i_lane_result (lane_result_i[g]),
      .i_lane_status (lane_status_i[g]),
      .i_retire      (w_retire[g]),
      .o_state       (w_state[g]),
      .o_lane_ready  (lane_out_ready_o[g]),
      .o_result      (w_result[g]),
      .o_status      (w_status[g]),
      .o_tag         (w_tag[g])
    );
  end

  // Dispatch and retire pointers; flush rewinds both to lane 0.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_dp <= '0;
      r_rp <= '0;
    end else if (flush_i) begin
      r_dp <= '0;
      r_rp <= '0;
    end else begin
      if (w_accept)    r_dp <= PtrW'(ptr_inc(32'(r_dp), NUM_LANES));
      if (w_retire_hs) r_rp <= PtrW'(ptr_inc(32'(r_rp), NUM_LANES));
    end
  end

endmodule

// File: tb/tb_pipe_fp_divsqrt_rr.sv
// Bench for pipe_fp_divsqrt_rr: behavioural lanes with per-lane latency,
// in-order scoreboard on the output side, one task per scenario.
module tb_pipe_fp_divsqrt_rr;
  import fp_divsqrt_rr_pkg::*;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned NUM_LANES = 5;
  typedef logic [3:0] tag_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    status_t          st;
    tag_t             tag;
  } exp_t;

  logic                            clk = 1'b0;
  logic                            rst = 1'b0;
  logic                            flush_i;
  logic                            in_valid_i;
  logic                            in_ready_o;
  logic [1:0][WIDTH-1:0]           operands_i;
  operation_e                      op_i;
  roundmode_e                      rnd_mode_i;
  tag_t                            tag_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [WIDTH-1:0]                result_o;
  status_t                         status_o;
  tag_t                            tag_o;
  logic                            busy_o;
  logic [NUM_LANES-1:0]            lane_in_valid_o;
  logic [NUM_LANES-1:0]            lane_in_ready_i;
  logic [1:0][WIDTH-1:0]           lane_operands_o;
  operation_e                      lane_op_o;
  roundmode_e                      lane_rnd_mode_o;
  logic [NUM_LANES-1:0]            lane_out_valid_i;
  logic [NUM_LANES-1:0]            lane_out_ready_o;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_result_i;
  status_t [NUM_LANES-1:0]         lane_status_i;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [NUM_LANES-1:0] m_busy;
  int unsigned          m_cnt [NUM_LANES];
  logic [WIDTH-1:0]     m_res [NUM_LANES];
  status_t              m_st  [NUM_LANES];
  int unsigned          lat   [NUM_LANES];

  pipe_fp_divsqrt_rr #(
    .WIDTH     (WIDTH),
    .NUM_LANES (NUM_LANES),
    .TagType   (tag_t)
  ) dut (
    .CLK_i            (clk),
    .RST_i            (rst),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .operands_i       (operands_i),
    .op_i             (op_i),
    .rnd_mode_i       (rnd_mode_i),
    .tag_i            (tag_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .result_o         (result_o),
    .status_o         (status_o),
    .tag_o            (tag_o),
    .busy_o           (busy_o),
    .lane_in_valid_o  (lane_in_valid_o),
    .lane_in_ready_i  (lane_in_ready_i),
    .lane_operands_o  (lane_operands_o),
    .lane_op_o        (lane_op_o),
    .lane_rnd_mode_o  (lane_rnd_mode_o),
    .lane_out_valid_i (lane_out_valid_i),
    .lane_out_ready_o (lane_out_ready_o),
    .lane_result_i    (lane_result_i),
    .lane_status_i    (lane_status_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in arithmetic: spec'd values for the ops under test, an arbitrary mix otherwise.
  function automatic logic [WIDTH-1:0] ref_res(input operation_e op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    if (op == OP_SQRT) return (a == 16'h4400) ? 16'h4000 : (a ^ 16'h1234);
    if (b == 16'h0000) return 16'h7C00;
    if (a == 16'h3C00 && b == 16'h4000) return 16'h3800;
    return a ^ b ^ 16'h1234;
  endfunction

  function automatic status_t ref_st(input operation_e op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input roundmode_e rm);
    if (op == OP_SQRT && a == 16'h4400) return status_t'(5'b00000);
    if (op == OP_DIV && b == 16'h0000) return status_t'(5'b01000);
    if (op == OP_DIV && a == 16'h3C00 && b == 16'h4000) return status_t'(5'b00000);
    return status_t'({2'b00, rm});
  endfunction

  // Behavioural iterative lanes: busy from issue until the result handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        m_busy[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_res[i]  <= '0;
        m_st[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (m_busy[i]) begin
          if (m_cnt[i] != 0) m_cnt[i] <= m_cnt[i] - 1;
          else if (lane_out_ready_o[i]) m_busy[i] <= 1'b0;
        end else if (lane_in_valid_o[i]) begin
          m_busy[i] <= 1'b1;
          m_cnt[i]  <= lat[i] - 1;
          m_res[i]  <= ref_res(lane_op_o, lane_operands_o[0], lane_operands_o[1]);
          m_st[i]   <= ref_st(lane_op_o, lane_operands_o[0], lane_operands_o[1], lane_rnd_mode_o);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_in_ready_i[i]  = ~m_busy[i];
      lane_out_valid_i[i] = m_busy[i] && (m_cnt[i] == 0);
      lane_result_i[i]    = m_res[i];
      lane_status_i[i]    = m_st[i];
    end
  end

  // Scoreboard: push on accepted issue, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst && !flush_i) begin
      if (in_valid_i && in_ready_o)
        sb.push_back({ref_res(op_i, operands_i[0], operands_i[1]),
                      ref_st(op_i, operands_i[0], operands_i[1], rnd_mode_i), tag_i});
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got res=%h st=%b tag=%h, required no output", result_o, status_o, tag_o);
        end else begin
          mon_e = sb.pop_front();
          if ({result_o, status_o, tag_o} !== mon_e) begin
            failures++;
            $display("FAIL sb_result: got res=%h st=%b tag=%h, required res=%h st=%b tag=%h",
                     result_o, status_o, tag_o, mon_e.res, mon_e.st, mon_e.tag);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input operation_e op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input roundmode_e rm, input tag_t t);
    in_valid_i    = v;
    op_i          = op;
    operands_i[0] = a;
    operands_i[1] = b;
    rnd_mode_i    = rm;
    tag_i         = t;
  endtask

  task automatic set_lat(input int unsigned l);
    for (int i = 0; i < NUM_LANES; i++) lat[i] = l;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid_o, busy_o, lane_in_valid_o, lane_out_ready_o, in_ready_o} !== {12'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_ctrl: got ov=%b busy=%b liv=%b lor=%b ir=%b, required 0 0 00000 00000 1",
               out_valid_o, busy_o, lane_in_valid_o, lane_out_ready_o, in_ready_o);
    end
    checks++;
    if ({result_o, status_o, tag_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: got res=%h st=%b tag=%h, required 0", result_o, status_o, tag_o);
    end
    set_lat(20);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 drive(1'b1, OP_DIV, 16'h3C00, 16'h4000, RNE, tag_t'(k));
      @(negedge clk);
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || lane_out_ready_o !== 5'b00111) begin
      failures++;
      $display("FAIL reset_pre_busy: got busy=%b lor=%b, required 1 00111", busy_o, lane_out_ready_o);
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_o, busy_o, lane_in_valid_o, lane_out_ready_o, result_o, status_o, tag_o} !== '0) begin
      failures++;
      $display("FAIL reset_midop: got ov=%b busy=%b liv=%b lor=%b res=%h tag=%h, required all 0",
               out_valid_o, busy_o, lane_in_valid_o, lane_out_ready_o, result_o, tag_o);
    end
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    set_lat(4);
    drive(1'b1, OP_SQRT, 16'h4400, 16'h0000, RNE, 4'h3);
    @(negedge clk);
    checks++;
    if (lane_in_valid_o !== 5'b00001 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_dp0: got liv=%b ir=%b, required 00001 1", lane_in_valid_o, in_ready_o);
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL reset_drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_single();
    int t0;
    logic got;
    do_reset();
    set_lat(4);
    drive(1'b1, OP_SQRT, 16'h4400, 16'h0000, RNE, 4'h5);
    @(negedge clk);
    t0 = cyc;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL single_accept: got ir=%b required 1", in_ready_o);
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_o) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || cyc - t0 != 5) begin
      failures++;
      $display("FAIL single_latency: got seen=%b cycles=%0d, required 1 5", got, cyc - t0);
    end
    @(posedge clk); #1 drive(1'b1, OP_DIV, 16'h3C00, 16'h0000, RTZ, 4'hF);
    @(posedge clk); #1 in_valid_i = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL single_drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int use_cnt [NUM_LANES];
    do_reset();
    set_lat(3);
    for (int i = 0; i < NUM_LANES; i++) use_cnt[i] = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 drive(1'b1, OP_DIV, 16'h3C00, 16'h4000, RNE, tag_t'(k));
      @(negedge clk);
      checks++;
      if (in_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready: op %0d got ir=%b required 1", k, in_ready_o);
      end
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_in_valid_o[i] && lane_in_ready_i[i]) use_cnt[i]++;
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      checks++;
      if (use_cnt[i] != 2) begin
        failures++;
        $display("FAIL b2b_lane_use: lane %0d got %0d issues, required 2", i, use_cnt[i]);
      end
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_out_of_order();
    int t0;
    do_reset();
    set_lat(3);
    lat[0] = 8;
    lat[1] = 2;
    t0 = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 drive(1'b1, OP_DIV, 16'h2000 + 16'(k), 16'h0300, RUP, tag_t'(k));
      @(negedge clk);
      if (k == 0) t0 = cyc;
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    while (cyc < t0 + 6) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || lane_out_ready_o !== 5'b00001 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL ooo_hold: got ov=%b lor=%b busy=%b, required 0 00001 1",
               out_valid_o, lane_out_ready_o, busy_o);
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL ooo_drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int nxt;
    logic have;
    logic [WIDTH-1:0] hold_res;
    tag_t hold_tag;
    do_reset();
    set_lat(2);
    acc = 0; nxt = 0; have = 1'b0; hold_res = '0; hold_tag = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      drive(1'b1, OP_DIV, 16'h1000 + 16'(nxt), 16'h0100, RDN, tag_t'(nxt));
      @(negedge clk);
      if (out_valid_o) begin
        if (have) begin
          checks++;
          if (result_o !== hold_res || tag_o !== hold_tag) begin
            failures++;
            $display("FAIL bp_stable: got res=%h tag=%h, required res=%h tag=%h",
                     result_o, tag_o, hold_res, hold_tag);
          end
        end
        hold_res = result_o; hold_tag = tag_o; have = 1'b1;
      end
      if (in_ready_o) begin acc++; nxt++; end
    end
    checks++;
    if (acc != 5 || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got accepts=%0d ir=%b, required 5 0", acc, in_ready_o);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    drive(1'b1, OP_DIV, 16'h1000 + 16'(nxt), 16'h0100, RDN, tag_t'(nxt));
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got ir=%b ov=%b, required 0 1", in_ready_o, out_valid_o);
    end
    for (int k = 0; k < 40 && acc < 8; k++) begin
      @(posedge clk); #1 drive(1'b1, OP_DIV, 16'h1000 + 16'(nxt), 16'h0100, RDN, tag_t'(nxt));
      @(negedge clk);
      if (in_ready_o) begin acc++; nxt++; end
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    checks++;
    if (acc != 8) begin
      failures++;
      $display("FAIL bp_resume: got accepts=%0d required 8", acc);
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_flush();
    int t0;
    do_reset();
    set_lat(20);
    lat[3] = 1;
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 drive(1'b1, OP_SQRT, 16'h5000 + 16'(k), 16'h0000, RMM, tag_t'(k));
      @(negedge clk);
      if (k == 0) t0 = cyc;
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    while (cyc < t0 + 6) @(negedge clk);
    checks++;
    if (lane_out_ready_o !== 5'b00111 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_pre: got lor=%b ov=%b, required 00111 0", lane_out_ready_o, out_valid_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b1;
    lat[0]  = 3;
    drive(1'b1, OP_SQRT, 16'h4400, 16'h0000, RNE, 4'hA);
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b0 || lane_in_valid_o !== 5'b00000) begin
      failures++;
      $display("FAIL flush_block: got ir=%b liv=%b, required 0 00000", in_ready_o, lane_in_valid_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (lane_out_ready_o !== 5'b00111 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_drain_state: got lor=%b ov=%b ir=%b busy=%b, required 00111 0 0 1",
               lane_out_ready_o, out_valid_o, in_ready_o, busy_o);
    end
    for (int k = 0; k < 40 && !in_ready_o; k++) @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1 || cyc - t0 != 21 || lane_in_valid_o !== 5'b00001) begin
      failures++;
      $display("FAIL flush_reissue: got ir=%b cycle=%0d liv=%b, required 1 21 00001",
               in_ready_o, cyc - t0, lane_in_valid_o);
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    for (int k = 0; k < 100 && (sb.size() != 0 || busy_o); k++) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_drain: got pending=%0d busy=%b, required 0 0", sb.size(), busy_o);
    end
  endtask

  initial begin
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    drive(1'b0, OP_DIV, 16'h0000, 16'h0000, RNE, 4'h0);
    set_lat(4);
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_order();
    test_backpressure();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
